// File: rtl/ct_mmu_sysmap_pkg.sv
// Shared types and constants for the MMU sysmap physical-address attribute lookup.
package ct_mmu_sysmap_pkg;

  localparam int unsigned SYSMAP_ENTRY_NUM = 8;
  localparam int unsigned SYSMAP_FLG_W     = 5;
  localparam int unsigned SYSMAP_PA_W      = 40;
  localparam int unsigned SYSMAP_UPADDR_W  = SYSMAP_PA_W - 12;

  // Attribute flags, MSB first: {SO, C, B, SH, SEC}
  typedef struct packed {
    logic so;
    logic c;
    logic b;
    logic sh;
    logic sec;
  } sysmap_flg_t;

  // One region register: exclusive 4KB-aligned top address plus its flags
  typedef struct packed {
    logic [SYSMAP_UPADDR_W-1:0] upaddr;
    sysmap_flg_t                flg;
  } sysmap_entry_t;

  // Strongly-ordered, everything else cleared; returned when no region hits
  localparam sysmap_flg_t SYSMAP_DFLT_FLG = '{so: 1'b1, c: 1'b0, b: 1'b0, sh: 1'b0, sec: 1'b0};

endpackage

// File: rtl/ct_mmu_sysmap_hit.sv
// Per-entry sysmap hit stage.
// Ports:
//   pa_i             page address PA[PA_W-1:12] under lookup
//   upaddr_i         exclusive top page address of this entry
//   addr_ge_bottom_i pa >= bottom of this entry (previous entry's top)
//   addr_ge_upaddr_o pa >= this entry's top; becomes the next entry's bottom compare
//   mmu_hit_o        pa lies in [bottom, upaddr)
module ct_mmu_sysmap_hit
  import ct_mmu_sysmap_pkg::*;
#(
  parameter int unsigned UPADDR_W = SYSMAP_UPADDR_W
) (
  input  logic [UPADDR_W-1:0] pa_i,
  input  logic [UPADDR_W-1:0] upaddr_i,
  input  logic                addr_ge_bottom_i,
  output logic                addr_ge_upaddr_o,
  output logic                mmu_hit_o
);

  logic comp_hit;

  assign comp_hit         = (pa_i < upaddr_i);
  assign addr_ge_upaddr_o = !comp_hit;
  assign mmu_hit_o        = addr_ge_bottom_i && comp_hit;

endmodule

// File: rtl/ct_mmu_sysmap_lookup.sv
// Two-stage pipelined physical-address attribute lookup against 8 sysmap regions.
// Ports:
//   forever_cpuclk / cpurst         clock, asynchronous active-high reset
//   lookup_req_vld/pa/tag, _rdy     request side handshake (accept on vld && rdy)
//   lookup_rsp_vld/flg/idx/hit/tag  response side, held stable while vld && !rdy
//   lookup_rsp_rdy                  consumer ready
//   cfg_wr_vld/idx/upaddr/flg       region register write
//   lookup_flush                    drop every in-flight request
module ct_mmu_sysmap_lookup
  import ct_mmu_sysmap_pkg::*;
#(
  parameter int unsigned      PA_W      = SYSMAP_PA_W,
  parameter int unsigned      ENTRY_NUM = SYSMAP_ENTRY_NUM,
  parameter int unsigned      FLG_W     = SYSMAP_FLG_W,
  parameter logic [FLG_W-1:0] DFLT_FLG  = SYSMAP_DFLT_FLG,
  parameter int unsigned      TAG_W     = 4
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              lookup_req_vld,
  input  logic [PA_W-1:0]   lookup_req_pa,
  input  logic [TAG_W-1:0]  lookup_req_tag,
  output logic              lookup_req_rdy,
  output logic              lookup_rsp_vld,
  output logic [FLG_W-1:0]  lookup_rsp_flg,
  output logic [2:0]        lookup_rsp_idx,
  output logic              lookup_rsp_hit,
  output logic [TAG_W-1:0]  lookup_rsp_tag,
  input  logic              lookup_rsp_rdy,
  input  logic              cfg_wr_vld,
  input  logic [2:0]        cfg_wr_idx,
  input  logic [PA_W-13:0]  cfg_wr_upaddr,
  input  logic [FLG_W-1:0]  cfg_wr_flg,
  input  logic              lookup_flush
);

  localparam int unsigned UPW = PA_W - 12;

  sysmap_entry_t entry_q [ENTRY_NUM];

  logic             s1_vld_q,  s1_vld_d;
  logic [UPW-1:0]   s1_pa_q,   s1_pa_d;
  logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [FLG_W-1:0] rsp_flg_q, rsp_flg_d;
  logic [2:0]       rsp_idx_q, rsp_idx_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic [ENTRY_NUM-1:0] ge_bottom;
  logic [ENTRY_NUM-1:0] ge_upaddr;
  logic [ENTRY_NUM-1:0] mmu_hit;
  logic                 sel_hit;
  logic [2:0]           sel_idx;
  logic [FLG_W-1:0]     sel_flg;
  logic                 s2_adv;
  logic                 unused_bits;

  // Region registers; untouched by flush
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        entry_q[i] <= '{upaddr: '0, flg: sysmap_flg_t'(DFLT_FLG)};
      end
    end else if (cfg_wr_vld) begin
      entry_q[cfg_wr_idx] <= '{upaddr: cfg_wr_upaddr, flg: sysmap_flg_t'(cfg_wr_flg)};
    end
  end

  // Region i's bottom compare is region i-1's top compare; region 0 starts at 0
  assign ge_bottom = {ge_upaddr[ENTRY_NUM-2:0], 1'b1};

  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_hit
    ct_mmu_sysmap_hit #(
      .UPADDR_W (UPW)
    ) u_hit (
      .pa_i             (s1_pa_q),
      .upaddr_i         (entry_q[g].upaddr),
      .addr_ge_bottom_i (ge_bottom[g]),
      .addr_ge_upaddr_o (ge_upaddr[g]),
      .mmu_hit_o        (mmu_hit[g])
    );
  end

  // Lowest hitting index wins; this alone resolves overlapping programming
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    sel_flg = DFLT_FLG;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (mmu_hit[i] && !sel_hit) begin
        sel_hit = 1'b1;
        sel_idx = 3'(i);
        sel_flg = entry_q[i].flg;
      end
    end
  end

  assign s2_adv         = !rsp_vld_q || lookup_rsp_rdy;
  assign lookup_req_rdy = !s1_vld_q || s2_adv;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_pa_d   = s1_pa_q;
    s1_tag_d  = s1_tag_q;
    rsp_vld_d = rsp_vld_q;
    rsp_flg_d = rsp_flg_q;
    rsp_idx_d = rsp_idx_q;
    rsp_hit_d = rsp_hit_q;
    rsp_tag_d = rsp_tag_q;

    if (lookup_req_rdy) begin
      s1_vld_d = lookup_req_vld;
      if (lookup_req_vld) begin
        s1_pa_d  = lookup_req_pa[PA_W-1:12];
        s1_tag_d = lookup_req_tag;
      end
    end

    // Flags are captured alongside the hit so later cfg writes cannot alter a held response
    if (s2_adv) begin
      rsp_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        rsp_flg_d = sel_flg;
        rsp_idx_d = sel_idx;
        rsp_hit_d = sel_hit;
        rsp_tag_d = s1_tag_q;
      end
    end

    if (lookup_flush) begin
      s1_vld_d  = 1'b0;
      rsp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      s1_vld_q  <= 1'b0;
      s1_pa_q   <= '0;
      s1_tag_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_flg_q <= '0;
      rsp_idx_q <= '0;
      rsp_hit_q <= 1'b0;
      rsp_tag_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_pa_q   <= s1_pa_d;
      s1_tag_q  <= s1_tag_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_flg_q <= rsp_flg_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  assign lookup_rsp_vld = rsp_vld_q;
  assign lookup_rsp_flg = rsp_flg_q;
  assign lookup_rsp_idx = rsp_idx_q;
  assign lookup_rsp_hit = rsp_hit_q;
  assign lookup_rsp_tag = rsp_tag_q;

  // Page offset and the last entry's top compare have no consumer
  assign unused_bits = ^{lookup_req_pa[11:0], ge_upaddr[ENTRY_NUM-1]};

endmodule

// File: tb/tb_ct_mmu_sysmap_lookup.sv
// Self-checking bench for ct_mmu_sysmap_lookup: vector table plus hand-written
// backpressure, config-hazard, flush and reset sequences, scoreboarded by tag order.
module tb_ct_mmu_sysmap_lookup;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic [39:0] req_pa = '0;
  logic [3:0]  req_tag = '0;
  logic        req_rdy;
  logic        rsp_vld;
  logic [4:0]  rsp_flg;
  logic [2:0]  rsp_idx;
  logic        rsp_hit;
  logic [3:0]  rsp_tag;
  logic        rsp_rdy = 1'b1;
  logic        cfg_vld = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [27:0] cfg_up = '0;
  logic [4:0]  cfg_flg = '0;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  ct_mmu_sysmap_lookup #(
    .PA_W      (40),
    .ENTRY_NUM (8),
    .FLG_W     (5),
    .DFLT_FLG  (5'b10000),
    .TAG_W     (4)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .lookup_req_vld (req_vld),
    .lookup_req_pa  (req_pa),
    .lookup_req_tag (req_tag),
    .lookup_req_rdy (req_rdy),
    .lookup_rsp_vld (rsp_vld),
    .lookup_rsp_flg (rsp_flg),
    .lookup_rsp_idx (rsp_idx),
    .lookup_rsp_hit (rsp_hit),
    .lookup_rsp_tag (rsp_tag),
    .lookup_rsp_rdy (rsp_rdy),
    .cfg_wr_vld     (cfg_vld),
    .cfg_wr_idx     (cfg_idx),
    .cfg_wr_upaddr  (cfg_up),
    .cfg_wr_flg     (cfg_flg),
    .lookup_flush   (flush)
  );

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
    logic [4:0] flg;
    logic [3:0] tag;
  } exp_t;

  typedef struct packed {
    logic [39:0] pa;
    logic        hit;
    logic [2:0]  idx;
    logic [4:0]  flg;
  } vec_t;

  exp_t        exp_q [$];
  vec_t        tbl [10];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic [2:0] i, input logic [4:0] f);
    mk = '{hit: h, idx: i, flg: f, tag: 4'h0};
  endfunction

  // Response scoreboard: a transfer happens at the posedge after a negedge with vld && rdy
  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got response tag 0x%0h, expected none", rsp_tag);
      end else begin : pop
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
        chk("rsp_idx", 64'(rsp_idx), 64'(e.idx));
        chk("rsp_flg", 64'(rsp_flg), 64'(e.flg));
      end
    end
  end

  // Called and returns at posedge+1; the expectation is queued once acceptance is certain
  task automatic send(input logic [39:0] pa, input logic [3:0] tag, input exp_t e);
    int unsigned n;
    n = 0;
    e.tag   = tag;
    req_vld = 1'b1;
    req_pa  = pa;
    req_tag = tag;
    @(negedge clk);
    while (!req_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (req_rdy) begin
      exp_q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_rdy=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [27:0] up, input logic [4:0] f);
    cfg_vld = 1'b1;
    cfg_idx = idx;
    cfg_up  = up;
    cfg_flg = f;
    @(posedge clk); #1;
    cfg_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{pa: 40'hFF_FFFF_F000, hit: 1'b0, idx: 3'd0, flg: 5'h10};
    tbl[1] = '{pa: 40'h00_0000_0000, hit: 1'b1, idx: 3'd0, flg: 5'h01};
    tbl[2] = '{pa: 40'h00_000F_F000, hit: 1'b1, idx: 3'd0, flg: 5'h01};
    tbl[3] = '{pa: 40'h00_000F_FFFF, hit: 1'b1, idx: 3'd0, flg: 5'h01};
    tbl[4] = '{pa: 40'h00_0010_0000, hit: 1'b1, idx: 3'd1, flg: 5'h02};
    tbl[5] = '{pa: 40'h00_002F_FFFF, hit: 1'b1, idx: 3'd2, flg: 5'h04};
    tbl[6] = '{pa: 40'h00_0030_0000, hit: 1'b1, idx: 3'd7, flg: 5'h0A};
    tbl[7] = '{pa: 40'hFF_FFFF_E000, hit: 1'b1, idx: 3'd7, flg: 5'h0A};
    tbl[8] = '{pa: 40'hFF_FFFF_EFFF, hit: 1'b1, idx: 3'd7, flg: 5'h0A};
    tbl[9] = '{pa: 40'h00_0020_0000, hit: 1'b1, idx: 3'd2, flg: 5'h04};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("reset_req_rdy", 64'(req_rdy), 64'd1);
    chk("reset_rsp_flg", 64'(rsp_flg), 64'd0);
    chk("reset_rsp_idx", 64'(rsp_idx), 64'd0);
    chk("reset_rsp_hit", 64'(rsp_hit), 64'd0);
    chk("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Entries 3-6 stay 0 (never hit); entry 7 all-ones excludes only the top page
    cfg(3'd0, 28'h000_0100, 5'h01);
    cfg(3'd1, 28'h000_0200, 5'h02);
    cfg(3'd2, 28'h000_0300, 5'h04);
    cfg(3'd7, 28'hFFF_FFFF, 5'h0A);

    // Latency: response valid after the edge following acceptance
    send(40'h00_0015_0000, 4'h1, mk(1'b1, 3'd1, 5'h02));
    chk("latency_s1", 64'(rsp_vld), 64'd0);
    @(posedge clk); #1;
    chk("latency_s2", 64'(rsp_vld), 64'd1);
    wait_drain();

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].pa, 4'(i + 2), mk(tbl[i].hit, tbl[i].idx, tbl[i].flg));
    end
    wait_drain();

    // Back-to-back boundaries, no bubble
    send(40'h00_000F_F000, 4'hA, mk(1'b1, 3'd0, 5'h01));
    send(40'h00_0010_0000, 4'hB, mk(1'b1, 3'd1, 5'h02));
    send(40'h00_002F_FFFF, 4'hC, mk(1'b1, 3'd2, 5'h04));
    chk("b2b_vld_b", 64'(rsp_vld), 64'd1);
    chk("b2b_tag_b", 64'(rsp_tag), 64'hB);
    @(posedge clk); #1;
    chk("b2b_vld_c", 64'(rsp_vld), 64'd1);
    chk("b2b_tag_c", 64'(rsp_tag), 64'hC);
    wait_drain();

    // Backpressure: two accepts fill S1/S2, third waits, then all drain in order
    rsp_rdy = 1'b0;
    send(40'h00_0015_0000, 4'h1, mk(1'b1, 3'd1, 5'h02));
    send(40'h00_0010_0000, 4'h2, mk(1'b1, 3'd1, 5'h02));
    chk("bp_req_rdy_low", 64'(req_rdy), 64'd0);
    req_vld = 1'b1;
    req_pa  = 40'h00_002F_FFFF;
    req_tag = 4'h3;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_vld", 64'(rsp_vld), 64'd1);
      chk("bp_hold_tag", 64'(rsp_tag), 64'h1);
      chk("bp_hold_idx", 64'(rsp_idx), 64'd1);
      chk("bp_hold_flg", 64'(rsp_flg), 64'h02);
      chk("bp_hold_rdy", 64'(req_rdy), 64'd0);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 64'(req_rdy), 64'd1);
    exp_q.push_back('{hit: 1'b1, idx: 3'd2, flg: 5'h04, tag: 4'h3});
    @(posedge clk); #1;
    req_vld = 1'b0;
    wait_drain();

    // Config hazard: write lands at the edge that registers the S1 compare
    send(40'h00_0019_0000, 4'h8, mk(1'b1, 3'd1, 5'h02));
    cfg(3'd1, 28'h000_0180, 5'h02);
    wait_drain();
    send(40'h00_0019_0000, 4'h9, mk(1'b1, 3'd2, 5'h04));
    wait_drain();

    // Flush with S1 and S2 full under stall
    rsp_rdy = 1'b0;
    send(40'h00_0010_0000, 4'h4, mk(1'b1, 3'd1, 5'h02));
    send(40'h00_0010_0000, 4'h5, mk(1'b1, 3'd1, 5'h02));
    req_vld = 1'b1;
    req_pa  = 40'h00_0010_0000;
    req_tag = 4'h6;
    flush   = 1'b1;
    @(posedge clk); #1;
    flush   = 1'b0;
    req_vld = 1'b0;
    exp_q.delete();
    chk("flush_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("flush_req_rdy", 64'(req_rdy), 64'd1);
    rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_quiet", 64'(rsp_vld), 64'd0);

    // Flush on an empty pipe drops the request presented in the same cycle
    req_vld = 1'b1;
    req_pa  = 40'h00_0000_0000;
    req_tag = 4'h7;
    flush   = 1'b1;
    @(posedge clk); #1;
    flush   = 1'b0;
    req_vld = 1'b0;
    @(posedge clk); #1;
    chk("flush_drop_accept", 64'(rsp_vld), 64'd0);
    send(40'h00_000F_F000, 4'hD, mk(1'b1, 3'd0, 5'h01));
    wait_drain();

    // Asynchronous reset mid-stream; map returns to all-zero so nothing hits
    rsp_rdy = 1'b0;
    send(40'h00_0010_0000, 4'h3, mk(1'b1, 3'd1, 5'h02));
    send(40'h00_0010_0000, 4'h4, mk(1'b1, 3'd1, 5'h02));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst     = 1'b0;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    send(40'h00_0015_0000, 4'h5, mk(1'b0, 3'd0, 5'h10));
    send(40'h00_0000_0000, 4'h6, mk(1'b0, 3'd0, 5'h10));
    send(40'hFF_FFFF_E000, 4'h7, mk(1'b0, 3'd0, 5'h10));
    wait_drain();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
